simple_exec_core: RTL and testbench

Minimal single-issue RV32 execute core used for bring-up of the fetch/decode/write-back path. It owns the program counter, instruction register and 32×32 register file, and decodes and executes ADD, SUB and (optionally) ADDI. Instruction memory is external, combinational and addressed by the PC. It sits between the top-level test harness and the instruction memory model.

---
 rtl/simple_exec_pkg.sv | 18 +
 rtl/simple_exec_regfile.sv | 34 +++
 rtl/simple_exec_core.sv | 88 ++++++++
 tb/tb_simple_exec_core.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/simple_exec_pkg.sv
// Shared constants and decode helpers for the simple_exec_core bring-up core.
package simple_exec_pkg;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [XLEN-1:0] PC_RESET = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  function automatic logic [XLEN-1:0] sext_imm12(input logic [XLEN-1:0] ir);
    return {{20{ir[31]}}, ir[31:20]};
  endfunction
endpackage

// File: rtl/simple_exec_regfile.sv
// 32x32 register file: x0 hard-zero, two combinational read ports plus a debug
// read port, one synchronous write port, asynchronous active-low clear.
module simple_exec_regfile
  import simple_exec_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      dbg_addr,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            wr_en,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != 5'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // No bypass: a read of the register being written returns the old value.
  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/simple_exec_core.sv
// Single-issue RV32 execute core (ADD/SUB, optional ADDI) for fetch/decode/WB bring-up.
// ADDI support is enabled by defining SIMPLE_EXEC_CORE_ADDI_EN.
module simple_exec_core
  import simple_exec_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] alu_result,
  output logic            reg_we,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] ir_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= PC_RESET;
      ir_q <= '0;
    end else begin
      pc_q <= pc_q + PC_STEP;
      ir_q <= imem_data;
    end
  end

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  logic is_add;
  logic is_sub;
  logic is_addi;

  assign is_add = (opcode == OP_R) && (funct3 == F3_ADD) && (funct7 == F7_ADD);
  assign is_sub = (opcode == OP_R) && (funct3 == F3_ADD) && (funct7 == F7_SUB);
`ifdef SIMPLE_EXEC_CORE_ADDI_EN
  assign is_addi = (opcode == OP_IMM) && (funct3 == F3_ADD);
`else
  assign is_addi = 1'b0;
`endif

  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  always_comb begin
    alu_result = '0;
    if (is_add)      alu_result = rs1_data + rs2_data;
    else if (is_sub) alu_result = rs1_data - rs2_data;
`ifdef SIMPLE_EXEC_CORE_ADDI_EN
    else if (is_addi) alu_result = rs1_data + sext_imm12(ir_q);
`endif
  end

  assign reg_we      = is_add | is_sub | is_addi;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = ir_q;

  simple_exec_regfile u_regfile (
    .clock    (clock),
    .reset    (reset),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .dbg_addr (dbg_addr),
    .wr_addr  (rd),
    .wr_data  (alu_result),
    .wr_en    (reg_we),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dbg_data (dbg_data)
  );

endmodule

// File: tb/tb_simple_exec_core.sv
// Self-checking bench for simple_exec_core: directed program plus random
// instructions, compared each cycle against an architectural reference model.
module tb_simple_exec_core;

`ifdef SIMPLE_EXEC_CORE_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] alu_result;
  logic        reg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  logic [31:0] imem [64];

  assign imem_data = imem[imem_addr[7:2]];

  simple_exec_core dut (
    .clock       (clock),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .pc          (pc),
    .instruction (instruction),
    .alu_result  (alu_result),
    .reg_we      (reg_we),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Architectural state of the reference machine.
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [31:0] m_regs [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_ir = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
  endtask

  // Instruction semantics from the ISA rules, on plain integers.
  function automatic void model_exec(input logic [31:0] ir, output logic [31:0] res, output bit we);
    int unsigned op, f3, f7, r1, r2;
    op = ir & 32'h7f;
    f3 = (ir >> 12) & 32'h7;
    f7 = ir >> 25;
    r1 = (ir >> 15) & 32'h1f;
    r2 = (ir >> 20) & 32'h1f;
    res = 32'h0;
    we  = 1'b0;
    if (op == 51 && f3 == 0 && f7 == 0) begin
      res = m_regs[r1] + m_regs[r2];
      we  = 1'b1;
    end else if (op == 51 && f3 == 0 && f7 == 32) begin
      res = m_regs[r1] - m_regs[r2];
      we  = 1'b1;
    end else if (ADDI_EN && op == 19 && f3 == 0) begin
      res = m_regs[r1] + 32'($signed(ir) >>> 20);
      we  = 1'b1;
    end
  endfunction

  task automatic model_edge();
    logic [31:0] res;
    bit we;
    int unsigned rd;
    model_exec(m_ir, res, we);
    rd = (m_ir >> 7) & 32'h1f;
    if (we && rd != 0) m_regs[rd] = res;
    m_ir = imem[m_pc[7:2]];
    m_pc = m_pc + 32'd4;
  endtask

  task automatic cycle_and_check();
    logic [31:0] res;
    bit we;
    @(posedge clock);
    if (reset) model_edge();
    dbg_addr = 5'($urandom_range(0, 31));
    @(negedge clock);
    model_exec(m_ir, res, we);
    check("pc", pc, m_pc);
    check("instruction", instruction, m_ir);
    check("alu_result", alu_result, res);
    check("reg_we", {31'b0, reg_we}, {31'b0, we});
    check($sformatf("dbg_x%0d", dbg_addr), dbg_data, m_regs[dbg_addr]);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [31:0] w;
    rd  = 5'($urandom_range(7, 31));
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    imm = 12'($urandom);
    case ($urandom_range(0, 4))
      0: return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      1: return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      2: return {imm, rs1, 3'b000, rd, 7'b0010011};
      3: return {7'b0000000, rs2, rs1, 3'($urandom_range(1, 7)), rd, 7'b0110011};
      default: begin
        w = $urandom;
        w[11:7] = rd;
        return w;
      end
    endcase
  endfunction

  initial begin
    reset    = 1'b0;
    dbg_addr = 5'd0;
    imem[0] = 32'h0050_0093;   // addi x1,x0,5
    imem[1] = 32'h0010_8233;   // add  x4,x1,x1
    imem[2] = 32'h4012_02B3;   // sub  x5,x4,x1
    imem[3] = 32'hFFF0_0313;   // addi x6,x0,-1
    imem[4] = 32'h0070_0013;   // addi x0,x0,7
    imem[5] = 32'h0200_0033;   // unsupported funct7
    for (int i = 6; i < 64; i++) imem[i] = rand_instr();
    model_reset();

    #12;
    check("rst_pc", pc, 32'h0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_reg_we", {31'b0, reg_we}, 32'h0);
    check("rst_alu_result", alu_result, 32'h0);

    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 30; c++) cycle_and_check();

    // Asynchronous reset mid-program.
    @(negedge clock);
    #2 reset = 1'b0;
    model_reset();
    dbg_addr = 5'd1;
    #1;
    check("midrst_pc", pc, 32'h0);
    check("midrst_instruction", instruction, 32'h0);
    check("midrst_x1", dbg_data, 32'h0);
    cycle_and_check();
    reset = 1'b1;
    for (int c = 0; c < 80; c++) cycle_and_check();

    dbg_addr = 5'd1; #1;
    check("final_x1", dbg_data, ADDI_EN ? 32'd5 : 32'd0);
    dbg_addr = 5'd4; #1;
    check("final_x4", dbg_data, ADDI_EN ? 32'd10 : 32'd0);
    dbg_addr = 5'd5; #1;
    check("final_x5", dbg_data, ADDI_EN ? 32'd5 : 32'd0);
    dbg_addr = 5'd6; #1;
    check("final_x6", dbg_data, ADDI_EN ? 32'hFFFF_FFFF : 32'd0);
    dbg_addr = 5'd0; #1;
    check("final_x0", dbg_data, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
